// File: rtl/acondicionador_sensores_pkg.sv
// Shared sensor constants: conditioning defaults and the monitor's current threshold.
package acondicionador_sensores_pkg;

  // Width of the current sample and of the averaged output.
  localparam int unsigned SensN        = 5;
  // Consecutive stable cycles needed before a flag change is accepted.
  localparam int unsigned SensDebCyc   = 16;
  // log2 of the samples per averaging window.
  localparam int unsigned SensAvgLog2  = 2;

  // Over-current threshold used by the downstream safety monitor.
  localparam logic [SensN-1:0] CorrienteUmbral = 5'b01111;

endpackage

// File: rtl/acondicionador_sensores_antirebote.sv
// Two-flop synchroniser followed by a counting debouncer for one raw flag.
module antirebote
  import acondicionador_sensores_pkg::*;
#(
  parameter int unsigned DEB_CYC = SensDebCyc
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_out
);

  localparam int unsigned     CntW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYC - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_out;
  logic [CntW-1:0] r_cnt;

  // Bring the asynchronous raw flag into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed from the output for DEB_CYC cycles;
  // any return to the current output level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= 1'b0;
      r_cnt <= '0;
    end else if (r_sync2 == r_out) begin
      r_cnt <= '0;
    end else if (r_cnt == CntMax) begin
      r_out <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/acondicionador_sensores.sv
// Input conditioning for the safety monitor: debounced flags and block-averaged current.
module acondicionador_sensores
  import acondicionador_sensores_pkg::*;
#(
  parameter int unsigned N        = SensN,
  parameter int unsigned DEB_CYC  = SensDebCyc,
  parameter int unsigned AVG_LOG2 = SensAvgLog2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         interruptor_in,
  input  logic         temp_in,
  input  logic         humo_in,
  input  logic         adc_valid,
  input  logic [N-1:0] adc_dato,
  output logic         interruptor,
  output logic         temp,
  output logic         humo,
  output logic [N-1:0] corriente,
  output logic         corriente_valid
);

  // The accumulator carries AVG_LOG2 extra bits so a full window of maximum samples fits.
  localparam int unsigned      AccW     = N + AVG_LOG2;
  localparam int unsigned      ScntW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [ScntW-1:0] ScntLast = ScntW'((1 << AVG_LOG2) - 1);

  logic [AccW-1:0]  r_acc;
  logic [ScntW-1:0] r_scnt;
  logic [N-1:0]     r_corriente;
  logic             r_valid;
  logic [AccW-1:0]  w_suma;

  antirebote #(
    .DEB_CYC (DEB_CYC)
  ) u_interruptor (
    .clk   (clk),
    .rst_n (rst_n),
    .i_raw (interruptor_in),
    .o_out (interruptor)
  );

  antirebote #(
    .DEB_CYC (DEB_CYC)
  ) u_temp (
    .clk   (clk),
    .rst_n (rst_n),
    .i_raw (temp_in),
    .o_out (temp)
  );

  antirebote #(
    .DEB_CYC (DEB_CYC)
  ) u_humo (
    .clk   (clk),
    .rst_n (rst_n),
    .i_raw (humo_in),
    .o_out (humo)
  );

  // Include the current sample so a window closes on the same edge as its last sample.
  assign w_suma = r_acc + AccW'(adc_dato);

  // Block averager: accumulate 2^AVG_LOG2 samples, then publish the truncated mean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_scnt      <= '0;
      r_corriente <= '0;
      r_valid     <= 1'b0;
    end else if (adc_valid) begin
      if (r_scnt == ScntLast) begin
        r_corriente <= w_suma[AccW-1:AVG_LOG2];
        r_valid     <= 1'b1;
        r_acc       <= '0;
        r_scnt      <= '0;
      end else begin
        r_acc   <= w_suma;
        r_scnt  <= r_scnt + ScntW'(1);
        r_valid <= 1'b0;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign corriente       = r_corriente;
  assign corriente_valid = r_valid;

endmodule

// File: doc/acondicionador_sensores.md
# acondicionador_sensores

Input conditioning stage that sits directly upstream of the safety-monitor state machine. It synchronises and debounces the raw switch, temperature and smoke flags. It also block-averages the sampled current reading from the ADC interface. Its outputs (`interruptor`, `temp`, `humo`, `corriente`) drive the monitor's inputs of the same names, so the monitor only ever sees clean, glitch-free, clock-synchronous values.

## Interface
- `N`, 5: width of the current sample and of `corriente`.
- `DEB_CYC`, 16: consecutive stable cycles required to accept a flag change; legal range ≥2.
- `AVG_LOG2`, 2: log2 of the number of samples averaged per output update (4 samples by default).

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `interruptor_in`  in  1: raw enable switch; asynchronous and bouncy.
- `temp_in`  in  1: raw over-temperature flag; asynchronous.
- `humo_in`  in  1: raw smoke flag; asynchronous.
- `adc_valid`  in  1: one-cycle strobe, `adc_dato` valid this cycle; synchronous to `clk`.
- `adc_dato`  in  N: current sample, unsigned.
- `interruptor`  out  1: debounced switch.
- `temp`  out  1: debounced temperature flag.
- `humo`  out  1: debounced smoke flag.
- `corriente`  out  N: averaged current, held between updates.
- `corriente_valid`  out  1: one-cycle pulse when `corriente` updates.

## Operation
- Reset: every output is 0; synchronisers, debounce counters, accumulator and sample counter are all 0. Reset has effect immediately, even mid-debounce or mid-average.
- Each raw flag passes through a 2-flop synchroniser and then a debouncer.
- Debouncer:
  - Counter `cnt` of width clog2(DEB_CYC).
  - If sync == out: `cnt` <= 0.
  - Else if `cnt` == DEB_CYC-1: out <= sync and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Any reversal before the flip restarts the count from 0.
  - Rising and falling edges are treated identically.
- Averager:
  - Accumulator `acc` is N+AVG_LOG2 bits wide, so it cannot overflow.
  - Sample counter `scnt` is AVG_LOG2 bits wide.
  - On `adc_valid` with `scnt` < 2^AVG_LOG2-1: `acc` += `adc_dato` and `scnt`++.
  - On `adc_valid` with `scnt` == 2^AVG_LOG2-1: `corriente` <= (`acc` + `adc_dato`) >> AVG_LOG2 (truncating), `corriente_valid` <= 1, `acc` <= 0, `scnt` <= 0.
  - Otherwise `corriente_valid` <= 0.
- This is a block average, not a moving average. Samples are never dropped, because each window closes on the same edge it completes.

## Timing
- Flag latency: a raw level change that is stable from edge k appears on the output at edge k+2+DEB_CYC (18 cycles by default).
- Any glitch or bounce with a sampled width < DEB_CYC cycles produces no output change.
- Current latency: `corriente` and `corriente_valid` are registered on the edge that samples the final `adc_valid` of a window, and are visible the following cycle.
- Back-to-back `adc_valid` on every cycle is supported at full rate.
- `corriente_valid` is never high on two consecutive cycles unless AVG_LOG2 = 0.

## Structure
- Default constants (`N`, `DEB_CYC`, `AVG_LOG2`) live in the shared sensor package, alongside the monitor's current-threshold constant (5'b01111).
- Sub-module `antirebote`, parameterised by `DEB_CYC`, contains the synchroniser plus debouncer. It is instantiated three times.
- The averager stays inline in the top module.

## Test plan
- Reset: hold `rst_n`=0 with all raw inputs at 1 → every output is 0. After release, `temp` rises exactly 18 cycles later (DEB_CYC=16).
- Glitch rejection: `humo_in` high for 10 cycles then low → `humo` stays 0 and the counter returns to 0.
- Bounce: `interruptor_in` toggles every 3 cycles for 30 cycles, then holds 1 → `interruptor` rises 18 cycles after the last toggle.
- Average: samples 10, 12, 14, 16 on consecutive cycles → `corriente`=13 with a single `corriente_valid` pulse; `corriente` then holds 13.
- Width/truncation: samples 31, 31, 31, 30 → `corriente`=30 (123>>2), no wrap.
- Reset mid-window: samples 20, 20, then `rst_n` pulse, then four samples of 8 → `corriente`=8 and exactly one valid pulse after reset.
